// File: rtl/two_to_four_decoder_and.sv
// Registered 2-to-4 decoder: {A,B} is decoded with AND-of-literals and loaded
// into four output flops each clock; synchronous active-high reset clears them.
module two_to_four_decoder_and (
    input  logic clk,
    input  logic rst,
    input  logic A,
    input  logic B,
    output logic D0,
    output logic D1,
    output logic D2,
    output logic D3
);

    logic [3:0] dec;

    always_comb begin
        dec    = '0;
        dec[0] = ~A & ~B;
        dec[1] = ~A &  B;
        dec[2] =  A & ~B;
        dec[3] =  A &  B;
    end

    // Outputs come straight from flops, so A/B activity between edges never reaches them.
    always_ff @(posedge clk) begin
        if (rst) begin
            D0 <= 1'b0;
            D1 <= 1'b0;
            D2 <= 1'b0;
            D3 <= 1'b0;
        end else begin
            D0 <= dec[0];
            D1 <= dec[1];
            D2 <= dec[2];
            D3 <= dec[3];
        end
    end

endmodule

// File: tb/tb_two_to_four_decoder_and.sv
// Directed bench for two_to_four_decoder_and: reset, exhaustive decode, toggle
// sequence, hold between edges, mid-run reset, plus a running one-hot monitor.
module tb_two_to_four_decoder_and;

    logic clk;
    logic rst;
    logic A;
    logic B;
    logic D0, D1, D2, D3;

    int vectors = 0;
    int miscompares = 0;
    logic [3:0] exp_q[$];
    logic mon_on = 1'b0;
    logic last_rst = 1'b1;

    two_to_four_decoder_and dut (
        .clk (clk),
        .rst (rst),
        .A   (A),
        .B   (B),
        .D0  (D0),
        .D1  (D1),
        .D2  (D2),
        .D3  (D3)
    );

    // clock / reset block
    initial clk = 1'b0;
    always #5 clk = ~clk;

    initial begin
        #100000;
        $display("FAIL watchdog observed=timeout expected=finish");
        $fatal(1, "watchdog expired");
    end

    // Compare outputs against the oldest expected value.
    task automatic check(input string tag);
        logic [3:0] obs;
        logic [3:0] exp;
        obs = {D3, D2, D1, D0};
        if (exp_q.size() == 0) begin
            exp = 4'bxxxx;
        end else begin
            exp = exp_q.pop_front();
        end
        vectors++;
        assert (obs === exp) else begin
            miscompares++;
            $error("FAIL %s observed=%b expected=%b", tag, obs, exp);
        end
    endtask

    // Drive inputs away from the edge, clock once, sample 1 time unit after the edge.
    task automatic step(input logic r, input logic a, input logic b, input logic [3:0] exp, input string tag);
        @(negedge clk);
        rst = r;
        A   = a;
        B   = b;
        exp_q.push_back(exp);
        @(posedge clk);
        #1;
        check(tag);
    endtask

    // One-hot / all-zero monitor across the whole run.
    always @(posedge clk) last_rst <= rst;

    always @(negedge clk) begin
        if (mon_on) begin
            logic [3:0] o;
            logic ok;
            o  = {D3, D2, D1, D0};
            ok = ($countones(o) == 1) || (o == 4'b0000 && last_rst);
            vectors++;
            assert (ok === 1'b1) else begin
                miscompares++;
                $error("FAIL onehot observed=%b expected=onehot_or_zero_after_rst", o);
            end
        end
    end

    initial begin
        rst = 1'b1;
        A   = 1'b1;
        B   = 1'b1;

        // reset with A=B=1 for two edges
        step(1'b1, 1'b1, 1'b1, 4'b0000, "reset_e1");
        step(1'b1, 1'b1, 1'b1, 4'b0000, "reset_e2");
        mon_on = 1'b1;

        // exhaustive decode; first one is also the first edge out of reset
        step(1'b0, 1'b0, 1'b0, 4'b0001, "dec_00");
        step(1'b0, 1'b0, 1'b1, 4'b0010, "dec_01");
        step(1'b0, 1'b1, 1'b0, 4'b0100, "dec_10");
        step(1'b0, 1'b1, 1'b1, 4'b1000, "dec_11");

        // toggle: A every cycle, B every two cycles, starting at 00
        step(1'b0, 1'b0, 1'b0, 4'b0001, "tog_0");
        step(1'b0, 1'b1, 1'b0, 4'b0100, "tog_1");
        step(1'b0, 1'b0, 1'b1, 4'b0010, "tog_2");
        step(1'b0, 1'b1, 1'b1, 4'b1000, "tog_3");
        step(1'b0, 1'b0, 1'b0, 4'b0001, "tog_4");
        step(1'b0, 1'b1, 1'b0, 4'b0100, "tog_5");
        step(1'b0, 1'b0, 1'b1, 4'b0010, "tog_6");
        step(1'b0, 1'b1, 1'b1, 4'b1000, "tog_7");

        // hold: wiggle inputs between edges, outputs must not move
        step(1'b0, 1'b0, 1'b1, 4'b0010, "hold_base");
        A = 1'b1;
        B = 1'b0;
        #1;
        exp_q.push_back(4'b0010);
        check("hold_mid1");
        A = 1'b1;
        B = 1'b1;
        #1;
        exp_q.push_back(4'b0010);
        check("hold_mid2");
        A = 1'b0;
        B = 1'b1;
        step(1'b0, 1'b0, 1'b1, 4'b0010, "hold_after");

        // mid-run reset with 11 steady
        step(1'b0, 1'b1, 1'b1, 4'b1000, "mid_pre");
        step(1'b1, 1'b1, 1'b1, 4'b0000, "mid_rst");
        step(1'b0, 1'b1, 1'b1, 4'b1000, "mid_post");

        // reset wins over a simultaneous input change
        step(1'b1, 1'b0, 1'b0, 4'b0000, "rst_wins");
        step(1'b0, 1'b1, 1'b0, 4'b0100, "rst_exit_10");

        @(negedge clk);
        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule

// File: doc/two_to_four_decoder_and.md
TWO_TO_FOUR_DECODER_AND -- requirements
Module: two_to_four_decoder_and

Interface
REQ-001 The module SHALL have no parameters; all widths are fixed.
REQ-002 clk  input  1  single clock; all state updates on rising edge.
REQ-003 rst  input  1  synchronous, active-high reset, sampled on rising clk edge.
REQ-004 A  input  1  select MSB.
REQ-005 B  input  1  select LSB.
REQ-006 D0  output  1  high when registered select {A,B} = 2'b00.
REQ-007 D1  output  1  high when registered select {A,B} = 2'b01.
REQ-008 D2  output  1  high when registered select {A,B} = 2'b10.
REQ-009 D3  output  1  high when registered select {A,B} = 2'b11.

Function
REQ-010 Decode equations SHALL be AND-of-literals:
- D0 = ~A & ~B
- D1 = ~A & B
- D2 = A & ~B
- D3 = A & B
REQ-011 D0..D3 SHALL be driven directly from flip-flops, with no combinational path from A/B to any output.
REQ-012 On each rising clk edge with rst low, D0..D3 SHALL load the decode of the A/B values sampled at that edge.
- Latency: exactly 1 clock cycle.
REQ-013 Outputs SHALL hold their value between clock edges regardless of A/B activity.
REQ-014 Out of reset, exactly one of D0..D3 SHALL be high in every cycle (one-hot).
REQ-015 A and B SHALL be treated as synchronous to clk; input synchronizers are out of scope.
REQ-016 A/B changing every cycle SHALL produce a matching output change every cycle, each one cycle late.
- No cycle is skipped.
- No intermediate code appears.
REQ-017 X/Z on A or B is undefined input; outputs need not be one-hot in that cycle.

Reset
REQ-018 While rst is high at a rising clk edge, D0..D3 SHALL all be 0 after that edge, irrespective of A/B.
REQ-019 All-zero SHALL be the only legal non-one-hot output state, occurring only during or immediately after reset.
REQ-020 On the first rising edge with rst low, outputs SHALL load the decode of the current A/B.
- No extra wait cycles.
REQ-021 Reset asserted mid-operation SHALL clear all outputs at the next rising edge.
- rst wins over any simultaneous A/B change.
REQ-022 Before the first clock edge, output values are undefined.
- The bench SHALL apply reset before checking outputs.

Verification
REQ-023 Reset check: rst=1, A=1, B=1 for 2 edges -> D3..D0 = 0000 after each edge.
REQ-024 Exhaustive decode, rst=0, one edge per code:
- {A,B}=00 -> D3..D0 = 0001 after the next edge.
- {A,B}=01 -> 0010.
- {A,B}=10 -> 0100.
- {A,B}=11 -> 1000.
REQ-025 Toggle sequence: A toggles every cycle, B every 2 cycles, starting at 00.
- Outputs sequence 0001, 0100, 0010, 1000, repeating.
- Each value appears one cycle after its input.
REQ-026 Hold: change A/B between edges and back before the next edge -> outputs unchanged.
REQ-027 Mid-run reset: {A,B}=11 steady, D3=1; assert rst for one edge -> 0000; deassert -> 1000 after the next edge.
REQ-028 Assertion for the whole run: outputs are one-hot or all-zero in every cycle, and all-zero only per REQ-019.
